// File: rtl/pulpino_spi_pkg.sv
// Shared constants and state encoding for the PULPino SPI boot loader.
package pulpino_spi_pkg;

  localparam logic [7:0]  SPI_CMD_WR_MEM = 8'h02;
  localparam int unsigned CMD_BITS       = 8;
  localparam int unsigned ADDR_BITS      = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    CMD   = 3'd2,
    ADDR  = 3'd3,
    DATA  = 3'd4,
    HOLD  = 3'd5,
    GAP   = 3'd6,
    DONE  = 3'd7
  } boot_state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider for the boot loader: mode-0 clock plus per-bit start/end strobes.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic s_clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic bit_start,
  output logic bit_end
);

  localparam int unsigned    CW      = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0]  HALF_TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Dropping en parks the divider at the start of a low half, so the next
  // enable begins a bit immediately.
  always_ff @(posedge s_clk) begin
    if (rst || !en) begin
      cnt <= HALF_TC;
      sck <= 1'b0;
    end else if (cnt == '0) begin
      cnt <= HALF_TC;
      sck <= ~sck;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign bit_start = en && !sck && (cnt == HALF_TC);
  assign bit_end   = en &&  sck && (cnt == '0);

endmodule

// File: rtl/spi_boot_loader.sv
// SPI master that streams a ROM image into the PULPino SPI slave, then raises fetch_en.
//  state | meaning
//  IDLE  | waiting for start
//  SETUP | csn low, CLK_DIV cycles before the first SCK
//  CMD   | shifting the 8-bit write-memory command
//  ADDR  | shifting the 32-bit target address of the frame
//  DATA  | shifting 32-bit data words
//  HOLD  | csn still low, sck low, CLK_DIV cycles
//  GAP   | csn high for 2*CLK_DIV cycles between frames
//  DONE  | one-cycle done pulse, sets fetch_en
module spi_boot_loader
  import pulpino_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned NUM_WORDS   = 1024,
  parameter int unsigned BURST_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ROM_AW      = 16
) (
  input  logic              s_clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fetch_en,
  output logic              rom_rd,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              spi_csn,
  output logic              spi_sck,
  output logic              spi_mosi
);

  localparam int unsigned     WCW      = $clog2(NUM_WORDS + 1);
  localparam int unsigned     BW       = $clog2(BURST_WORDS + 1);
  localparam int unsigned     TW       = $clog2(2 * CLK_DIV + 1);
  localparam logic [WCW-1:0]  LAST_CNT = WCW'(NUM_WORDS);
  localparam logic [BW-1:0]   ONE_LEFT = BW'(1);

  if (NUM_WORDS == 0 || BURST_WORDS == 0 || CLK_DIV == 0) begin : g_param_chk
    $error("spi_boot_loader: NUM_WORDS, BURST_WORDS and CLK_DIV must all be >= 1");
  end

  boot_state_e    state;
  logic [31:0]    shreg;
  logic [31:0]    pf;
  logic           rd_q;
  logic [4:0]     bit_cnt;
  logic [TW-1:0]  tmr;
  logic [WCW-1:0] word_idx;
  logic [WCW-1:0] rd_idx;
  logic [BW-1:0]  burst_left;

  logic           shifting;
  logic           bit_start;
  logic           bit_end;
  logic [31:0]    next_word;
  logic [31:0]    frame_addr;
  logic [WCW-1:0] words_rem;
  logic [BW-1:0]  burst_load;

  assign shifting = state inside {CMD, ADDR, DATA};

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .s_clk     (s_clk),
    .rst       (rst),
    .en        (shifting),
    .sck       (spi_sck),
    .bit_start (bit_start),
    .bit_end   (bit_end)
  );

  // With CLK_DIV=1 the read data arrives on the word boundary itself.
  assign next_word  = rd_q ? rom_data : pf;
  assign frame_addr = BASE_ADDR + (32'(word_idx) << 2);
  assign words_rem  = LAST_CNT - word_idx;

  always_comb begin
    burst_load = BW'(BURST_WORDS);
    if (32'(words_rem) < BURST_WORDS) burst_load = BW'(words_rem);
  end

  assign rom_rd = bit_start && (bit_cnt == '0) &&
                  ((state == ADDR) || ((state == DATA) && (burst_left != ONE_LEFT)));

  always_ff @(posedge s_clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_en   <= 1'b0;
      shreg      <= '0;
      pf         <= '0;
      rd_q       <= 1'b0;
      bit_cnt    <= '0;
      tmr        <= '0;
      word_idx   <= '0;
      rd_idx     <= '0;
      burst_left <= '0;
    end else begin
      rd_q <= rom_rd;
      if (rd_q)   pf     <= rom_data;
      if (rom_rd) rd_idx <= rd_idx + WCW'(1);
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETUP;
            fetch_en <= 1'b0;
            word_idx <= '0;
            rd_idx   <= '0;
            tmr      <= TW'(CLK_DIV - 1);
          end
        end
        SETUP: begin
          if (tmr == '0) begin
            state   <= CMD;
            shreg   <= {SPI_CMD_WR_MEM, 24'h0};
            bit_cnt <= 5'(CMD_BITS - 1);
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        CMD, ADDR, DATA: begin
          if (bit_end) begin
            if (bit_cnt != '0) begin
              shreg   <= {shreg[30:0], 1'b0};
              bit_cnt <= bit_cnt - 5'd1;
            end else begin
              bit_cnt <= 5'(ADDR_BITS - 1);
              case (state)
                CMD: begin
                  state <= ADDR;
                  shreg <= frame_addr;
                end
                ADDR: begin
                  state      <= DATA;
                  shreg      <= next_word;
                  burst_left <= burst_load;
                end
                default: begin
                  word_idx <= word_idx + WCW'(1);
                  if (burst_left == ONE_LEFT) begin
                    state <= HOLD;
                    shreg <= '0;
                    tmr   <= TW'(CLK_DIV - 1);
                  end else begin
                    shreg      <= next_word;
                    burst_left <= burst_left - ONE_LEFT;
                  end
                end
              endcase
            end
          end
        end
        HOLD: begin
          if (tmr == '0) begin
            state <= GAP;
            tmr   <= TW'(2 * CLK_DIV - 1);
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        GAP: begin
          if (tmr == '0) begin
            if (word_idx == LAST_CNT) begin
              state <= DONE;
            end else begin
              state <= SETUP;
              tmr   <= TW'(CLK_DIV - 1);
            end
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          fetch_en <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign spi_csn  = !(state inside {SETUP, CMD, ADDR, DATA, HOLD});
  assign spi_mosi = shreg[31];
  assign rom_addr = ROM_AW'(rd_idx);

endmodule
